// File: rtl/rpc2_ctrl_fifo_wr_status.sv
// Write-side status stage of an async FIFO: synchronizes the read Gray pointer and
// produces registered full / almost_full / free count plus a sticky overflow flag.
module rpc2_ctrl_fifo_wr_status #(
  parameter int WIDTH        = 9,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_gray_ptr,
  input  logic [WIDTH-1:0] wr_next_gray_ptr,
  input  logic [WIDTH-1:0] rd_gray_ptr,
  input  logic             ovf_clr,
  output logic             wr_inc,
  output logic             full,
  output logic             almost_full,
  output logic [WIDTH-1:0] free_cnt,
  output logic             wr_ovf
);

  localparam int               DEPTH    = 2 ** (WIDTH - 1);
  localparam logic [WIDTH-1:0] DEPTH_W  = WIDTH'(DEPTH);
  localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(AFULL_THRESH);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] rd_gray_s;
  logic [WIDTH-1:0] full_match;
  logic [WIDTH-1:0] used;
  logic [WIDTH-1:0] free_next;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // NOTE: the synchronizer array is reset like ordinary flops so the first
  // post-reset status sees an empty FIFO rather than an X pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rd_gray_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rd_gray_s = sync_q[SYNC_STAGES-1];

  // Full when the next write pointer sits exactly one lap ahead of the read pointer.
  assign full_match = {~rd_gray_s[WIDTH-1:WIDTH-2], rd_gray_s[WIDTH-3:0]};
  assign used       = gray2bin(wr_next_gray_ptr) - gray2bin(rd_gray_s);
  assign free_next  = DEPTH_W - used;

  // NOTE: wr_inc is combinational but only from wr_req and the full flop, so the
  // write counter feeding wr_next_gray_ptr back into us forms no loop.
  assign wr_inc = wr_req & ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      free_cnt    <= DEPTH_W;
      wr_ovf      <= 1'b0;
    end else begin
      full        <= (wr_next_gray_ptr == full_match);
      almost_full <= (free_next <= THRESH_W);
      free_cnt    <= free_next;
      wr_ovf      <= (wr_req & full) | (wr_ovf & ~ovf_clr);
    end
  end

  // Equal pointers mean empty; a full flag at that moment means the pointers are corrupt.
  assert property (@(posedge clk) disable iff (!rst_n) (wr_gray_ptr == rd_gray_s) |-> !full)
    else $error("full asserted while write and synchronized read pointers are equal");

endmodule
